// File: rtl/btn_debounce.sv
// Debounced push-button with press / release / long-press events.
// Long-press support is built only when BTN_DEBOUNCE_LONGPRESS_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 96000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam logic REL_LVL = ACTIVE_LOW;
  localparam logic [23:0] DEB_LAST =
    24'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] C_PRESS = 2'b01;
  localparam logic [1:0] C_REL   = 2'b10;

  if (DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES > 16777215) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES ||
      LONG_CYCLES > 268435455) begin : g_bad_long
    $error("LONG_CYCLES out of range");
  end

  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    RELEASE_WAIT = 3'd3
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    , LONG_HELD  = 3'd4
`endif
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        sync0;
  logic        sync1;
  logic        s;
  logic [23:0] deb_cnt;
  logic        deb_done;
  logic        clr_deb;
  logic        inc_deb;
  logic        emit;
  logic [1:0]  emit_code;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam logic [27:0] HOLD_LAST =
    28'(LONG_CYCLES - 1);
  localparam logic [1:0] C_LONG = 2'b11;
  logic [27:0] hold_cnt;
  logic        hold_done;
  logic        long_seen;
  assign hold_done = (hold_cnt == HOLD_LAST);
`endif

  // two-flop synchronizer, idles at the released pin level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= REL_LVL;
      sync1 <= REL_LVL;
    end else begin
      sync0 <= btn_in;
      sync1 <= sync0;
    end
  end

  assign s        = ACTIVE_LOW ? ~sync1 : sync1;
  assign deb_done = (deb_cnt == DEB_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= RELEASED;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      RELEASED:
        if (s) state_nx = PRESS_WAIT;
      PRESS_WAIT:
        if (!s)           state_nx = RELEASED;
        else if (deb_done) state_nx = PRESSED;
      PRESSED:
        if (!s) state_nx = RELEASE_WAIT;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        else if (hold_done) state_nx = LONG_HELD;
      LONG_HELD:
        if (!s) state_nx = RELEASE_WAIT;
`endif
      RELEASE_WAIT:
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        if (s) state_nx = long_seen ? LONG_HELD
                                    : PRESSED;
`else
        if (s) state_nx = PRESSED;
`endif
        else if (deb_done) state_nx = RELEASED;
      default: state_nx = RELEASED;
    endcase
  end

  // level, event strobe and debounce counter controls
  always_comb begin
    btn_level = 1'b0;
    emit      = 1'b0;
    emit_code = 2'b00;
    clr_deb   = 1'b0;
    inc_deb   = 1'b0;
    unique case (state)
      RELEASED:
        clr_deb = s;
      PRESS_WAIT: begin
        inc_deb = s && !deb_done;
        if (s && deb_done) begin
          emit      = 1'b1;
          emit_code = C_PRESS;
        end
      end
      PRESSED: begin
        btn_level = 1'b1;
        clr_deb   = !s;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        if (s && hold_done) begin
          emit      = 1'b1;
          emit_code = C_LONG;
        end
`endif
      end
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
      LONG_HELD: begin
        btn_level = 1'b1;
        clr_deb   = !s;
      end
`endif
      RELEASE_WAIT: begin
        btn_level = 1'b1;
        inc_deb   = !s && !deb_done;
        if (!s && deb_done) begin
          emit      = 1'b1;
          emit_code = C_REL;
        end
      end
      default: btn_level = 1'b0;
    endcase
  end

  // debounce counter, saturating
  always_ff @(posedge clk) begin
    if (rst)
      deb_cnt <= '0;
    else if (clr_deb)
      deb_cnt <= 24'd1;
    else if (inc_deb && deb_cnt != '1)
      deb_cnt <= deb_cnt + 24'd1;
  end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  // hold counter survives release glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      long_seen <= 1'b0;
    end else if (state == PRESS_WAIT &&
                 state_nx == PRESSED) begin
      hold_cnt  <= '0;
      long_seen <= 1'b0;
    end else if (state == PRESSED && s) begin
      if (hold_done)
        long_seen <= 1'b1;
      else if (hold_cnt != '1)
        hold_cnt <= hold_cnt + 28'd1;
    end
  end
`endif

  // single-entry event register with sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid    <= 1'b0;
      evt_code     <= 2'b00;
      evt_overflow <= 1'b0;
    end else if (emit &&
                 (!evt_valid || evt_ready)) begin
      evt_valid <= 1'b1;
      evt_code  <= emit_code;
    end else if (emit) begin
      evt_overflow <= 1'b1;
    end else if (evt_valid && evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce.
// Long-press expectations follow BTN_DEBOUNCE_LONGPRESS_EN.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int L = 16;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       evt_ready;
  logic       btn_level;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_overflow;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .evt_valid(evt_valid),
    .evt_code(evt_code),
    .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
  );

  // reference: level flips after D consecutive
  // disagreeing samples of the synchronized pin
  logic       m_p1, m_p2, m_level;
  logic       m_valid, m_ovf, m_long;
  logic [1:0] m_code;
  int         m_run, m_hold;

  always @(posedge clk) begin : model
    logic s, e;
    logic [1:0] c;
    int pre;
    if (rst) begin
      m_p1 = 1'b1; m_p2 = 1'b1;
      m_level = 1'b0; m_run = 0;
      m_hold = 0; m_long = 1'b0;
      m_valid = 1'b0; m_code = 2'b00;
      m_ovf = 1'b0;
    end else begin
      s = ~m_p2; e = 1'b0; c = 2'b00;
      pre = m_run;
      if (s != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = s; m_run = 0;
          e = 1'b1;
          c = s ? 2'b01 : 2'b10;
          if (s) begin
            m_hold = 0; m_long = 1'b0;
          end
        end
      end else begin
        if (m_level && pre == 0 && !m_long) begin
          m_hold++;
          if (LONG_EN && m_hold == L) begin
            m_long = 1'b1;
            e = 1'b1; c = 2'b11;
          end
        end
        m_run = 0;
      end
      if (e && (!m_valid || evt_ready)) begin
        m_valid = 1'b1; m_code = c;
      end else if (e) begin
        m_ovf = 1'b1;
      end else if (m_valid && evt_ready) begin
        m_valid = 1'b0;
      end
      m_p2 = m_p1; m_p1 = btn_in;
    end
  end

  task automatic settle(input int n);
    btn_in = 1'b1;
    evt_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_in = 1'b1; evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({btn_level, evt_valid, evt_code,
         evt_overflow} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000",
        {btn_level, evt_valid, evt_code,
         evt_overflow});
    else passes++;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (btn_level !== 1'b0 || evt_valid !== 1'b0)
      $display("FAIL reset_idle: level=%b valid=%b want 0 0",
        btn_level, evt_valid);
    else passes++;
  endtask

  task automatic test_press_release();
    evt_ready = 1'b0;
    btn_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (k < 6) begin
        if (btn_level !== 1'b0 || evt_valid !== 1'b0)
          $display("FAIL press_early k=%0d: level=%b valid=%b want 0 0",
            k, btn_level, evt_valid);
        else passes++;
      end else begin
        if (btn_level !== 1'b1 || evt_valid !== 1'b1 ||
            evt_code !== 2'b01)
          $display("FAIL press_edge6: level=%b valid=%b code=%b want 1 1 01",
            btn_level, evt_valid, evt_code);
        else passes++;
      end
    end
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || evt_code !== 2'b01)
      $display("FAIL press_accept: valid=%b code=%b want 0 01",
        evt_valid, evt_code);
    else passes++;
    btn_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5 || k == 6) begin
        checks++;
        if (btn_level !== (k == 5) ||
            evt_valid !== (k == 6) ||
            (k == 6 && evt_code !== 2'b10))
          $display("FAIL release_k%0d: level=%b valid=%b code=%b want %b %b 10",
            k, btn_level, evt_valid, evt_code,
            k == 5, k == 6);
        else passes++;
      end
    end
  endtask

  task automatic test_glitch();
    settle(4);
    for (int w = 1; w <= 3; w++) begin
      btn_in = 1'b0;
      repeat (w) @(negedge clk);
      btn_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b0 || evt_valid !== 1'b0)
          $display("FAIL glitch_w%0d k=%0d: level=%b valid=%b want 0 0",
            w, k, btn_level, evt_valid);
        else passes++;
      end
    end
  endtask

  task automatic test_long_press();
    int found, n_long, at, n_other;
    settle(6);
    btn_in = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      if (btn_level === 1'b1) found = 1;
    end
    checks++;
    if (found == 0)
      $display("FAIL long_press_timeout: level=%b want 1",
        btn_level);
    else passes++;
    n_long = 0; at = -1; n_other = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (evt_valid === 1'b1 && evt_code === 2'b11) begin
        n_long++; at = k;
      end else if (evt_valid === 1'b1) n_other++;
      checks++;
      if (btn_level !== 1'b1 || evt_valid !== m_valid ||
          evt_code !== m_code)
        $display("FAIL long_hold k=%0d: got %b/%b/%b want 1/%b/%b",
          k, btn_level, evt_valid, evt_code,
          m_valid, m_code);
      else passes++;
    end
    checks++;
    if (LONG_EN) begin
      if (n_long != 1 || at != 16 || n_other != 0)
        $display("FAIL long_event: count=%0d at=%0d other=%0d want 1 16 0",
          n_long, at, n_other);
      else passes++;
    end else begin
      if (n_long != 0 || n_other != 0)
        $display("FAIL no_long_event: count=%0d other=%0d want 0 0",
          n_long, n_other);
      else passes++;
    end
    btn_in = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (btn_level !== 1'b0 || evt_valid !== 1'b1 ||
        evt_code !== 2'b10)
      $display("FAIL long_release: level=%b valid=%b code=%b want 0 1 10",
        btn_level, evt_valid, evt_code);
    else passes++;
  endtask

  task automatic test_overflow();
    settle(4);
    evt_ready = 1'b0;
    btn_in = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 2'b01 ||
        evt_overflow !== 1'b0)
      $display("FAIL ovf_press: valid=%b code=%b ovf=%b want 1 01 0",
        evt_valid, evt_code, evt_overflow);
    else passes++;
    btn_in = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (evt_overflow !== 1'b0)
      $display("FAIL ovf_early: ovf=%b want 0", evt_overflow);
    else passes++;
    @(negedge clk);
    checks++;
    if (btn_level !== 1'b0 || evt_valid !== 1'b1 ||
        evt_code !== 2'b01 || evt_overflow !== 1'b1)
      $display("FAIL ovf_release: level=%b valid=%b code=%b ovf=%b want 0 1 01 1",
        btn_level, evt_valid, evt_code, evt_overflow);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (evt_overflow !== 1'b1)
      $display("FAIL ovf_sticky: ovf=%b want 1", evt_overflow);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({btn_level, evt_valid, evt_code,
         evt_overflow} !== 5'b0)
      $display("FAIL ovf_reset: got %b want 00000",
        {btn_level, evt_valid, evt_code,
         evt_overflow});
    else passes++;
  endtask

  task automatic test_reset_mid_press();
    settle(4);
    btn_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b0 || btn_level !== 1'b0)
        $display("FAIL rst_mid k=%0d: valid=%b level=%b want 0 0",
          k, evt_valid, btn_level);
      else passes++;
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5 || k == 6) begin
        checks++;
        if (btn_level !== (k == 6) ||
            evt_valid !== (k == 6) ||
            (k == 6 && evt_code !== 2'b01))
          $display("FAIL rst_repress k=%0d: level=%b valid=%b code=%b want %b %b 01",
            k, btn_level, evt_valid, evt_code,
            k == 6, k == 6);
        else passes++;
      end
    end
    settle(12);
  endtask

  task automatic test_random();
    int run;
    logic lvl;
    run = 0; lvl = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (run == 0) begin
        run = $urandom_range(1, 24);
        lvl = 1'($urandom_range(0, 1));
      end
      btn_in = lvl;
      run--;
      evt_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      checks++;
      if (btn_level !== m_level ||
          evt_valid !== m_valid ||
          evt_code !== m_code ||
          evt_overflow !== m_ovf)
        $display("FAIL random n=%0d: got %b%b%b%b want %b%b%b%b",
          n, btn_level, evt_valid, evt_code,
          evt_overflow, m_level, m_valid, m_code,
          m_ovf);
      else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_glitch();
    test_long_press();
    test_overflow();
    test_reset_mid_press();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 480000, consecutive cycles of changed input required to accept a new level (5 ms at 96 MHz); legal range 2..2^24-1.
REQ-002 Parameter LONG_CYCLES, default 96000000, cycles held pressed before a long-press event; legal range DEBOUNCE_CYCLES+1..2^28-1.
REQ-003 Parameter ACTIVE_LOW, default 1, 1 = pin reads 0 when pressed.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_in  input  1  raw asynchronous button pin.
REQ-007 btn_level  output  1  debounced state, 1 = pressed.
REQ-008 evt_valid  output  1  event pending.
REQ-009 evt_code  output  2  01 press, 10 release, 11 long-press; 00 never presented while evt_valid=1.
REQ-010 evt_ready  input  1  consumer accepts event when evt_valid=1 and evt_ready=1.
REQ-011 evt_overflow  output  1  sticky: event lost because the previous one was not accepted.

Function
REQ-012 btn_in SHALL pass through a 2-flop synchronizer, then be inverted when ACTIVE_LOW=1, giving internal signal s.
REQ-013 FSM states: RELEASED, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
REQ-014 RELEASED: s=1 -> PRESS_WAIT, debounce counter cleared to 1.
REQ-015 PRESS_WAIT: s=0 -> RELEASED (glitch rejected, no event); s=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED, emit press; otherwise counter increments.
REQ-016 PRESSED: hold counter increments each cycle s=1; at LONG_CYCLES-1 -> LONG_HELD, emit long-press (once per press); s=0 -> RELEASE_WAIT, debounce counter cleared to 1.
REQ-017 LONG_HELD: s=0 -> RELEASE_WAIT; no further events while held.
REQ-018 RELEASE_WAIT: s=1 -> return to the pressed state it came from (PRESSED or LONG_HELD) with no event; hold counter is not reset by a rejected glitch; s=0 and counter=DEBOUNCE_CYCLES-1 -> RELEASED, emit release.
REQ-019 btn_level SHALL be 1 in PRESSED, LONG_HELD and RELEASE_WAIT, 0 otherwise; it changes in the same cycle evt_valid rises for press/release.
REQ-020 Latency: a clean input edge SHALL reach btn_level exactly 2+DEBOUNCE_CYCLES clock edges after first being sampled.
REQ-021 Event register: on emit with evt_valid=0, or evt_valid=1 and evt_ready=1 in the same cycle, load evt_code and set evt_valid=1.
REQ-022 Emit while evt_valid=1 and evt_ready=0: new event dropped, held event unchanged, evt_overflow set to 1.
REQ-023 Accept without new emit clears evt_valid next cycle; evt_code holds its last value.
REQ-024 Counters SHALL saturate, never wrap.

Reset
REQ-025 On rst=1 at a clock edge: FSM -> RELEASED, counters 0, synchronizer flops to released level, btn_level=0, evt_valid=0, evt_code=00, evt_overflow=0.
REQ-026 evt_overflow SHALL clear only on reset.
REQ-027 Reset asserted mid-debounce or mid-press SHALL emit no event; a button still held after reset produces a fresh press after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-028 Macro BTN_DEBOUNCE_LONGPRESS_EN defined: LONG_HELD state, hold counter and code 11 are present as specified.
REQ-029 Macro undefined: no hold counter or LONG_HELD state, code 11 never emitted, LONG_CYCLES ignored; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1, macro defined unless stated)
REQ-030 btn_in 1->0 held -> btn_level=1 and evt_valid=1, evt_code=01 exactly 6 edges later; evt_ready=1 -> evt_valid=0 next cycle.
REQ-031 btn_in low pulses of 1, 2 and 3 cycles -> no btn_level change, evt_valid stays 0.
REQ-032 Hold pressed 30 cycles past press with evt_ready=1 -> exactly one 11 event 16 cycles after press; release -> 10 event 6 edges after release.
REQ-033 evt_ready=0 throughout, press then release -> evt_code stays 01, evt_overflow=1 at release emit; rst -> all outputs 0.
REQ-034 rst pulsed during PRESS_WAIT with pin held low -> no event during reset; press event 6 edges after rst deasserts.
REQ-035 Macro undefined, hold 30 cycles -> only 01 then 10 events, never 11.
